// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner.
package keypad_pkg;

    // Scanner FSM states.
    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } state_t;

    // Hex value of each key, indexed by {row, col}; entry 0 is r0/col0.
    localparam logic [15:0][3:0] KEYMAP = {
        4'hD, 4'hE, 4'hF, 4'h0,   // r3: col3..col0
        4'hC, 4'h9, 4'h8, 4'h7,   // r2
        4'hB, 4'h6, 4'h5, 4'h4,   // r1
        4'hA, 4'h3, 4'h2, 4'h1    // r0
    };

    // Active-low column drive pattern for each column index.
    localparam logic [3:0][3:0] COL_N_TABLE = {
        4'b0111, 4'b1011, 4'b1101, 4'b1110
    };

    // Index of the lowest-numbered row that is pulled low (0 when none).
    function automatic logic [1:0] lowest_low_row(input logic [3:0] rows_n);
        logic [1:0] idx;
        idx = 2'd0;
        if (!rows_n[0])      idx = 2'd0;
        else if (!rows_n[1]) idx = 2'd1;
        else if (!rows_n[2]) idx = 2'd2;
        else if (!rows_n[3]) idx = 2'd3;
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scanner_sync_2ff.sv
// Two-flop synchronizer for asynchronous multi-bit level inputs.
module sync_2ff #(
    parameter int         WIDTH     = 4,
    parameter logic [3:0] RESET_VAL = 4'hF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // Two back-to-back flops; released-key level (all ones) out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= RESET_VAL[WIDTH-1:0];
            r_sync <= RESET_VAL[WIDTH-1:0];
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column drive, row sampling, debounce,
// valid/ack key presentation and a 32-bit shift-in entry word.
//
// Handshake: key_valid rises on the edge after an accepted key and stays
// high with key_code stable until a cycle with key_ack=1, after which it
// clears on the next edge. key_ack with key_valid=0 is ignored. An accept
// in the same cycle as key_ack wins: key_valid stays 1 with the new code.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 5000,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  row_n,
    output logic [3:0]  col_n,
    output logic        key_valid,
    output logic [3:0]  key_code,
    input  logic        key_ack,
    output logic        key_held,
    output logic        overrun,
    input  logic        clr,
    output logic [31:0] entry,
    output state_t      dbg_state
);

    localparam int DW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);

    logic [3:0]       w_row_s;
    logic [DW-1:0]    r_dwell;
    logic             w_sample;
    logic             w_all_high;

    state_t           r_state;
    state_t           w_state_next;
    logic [1:0]       r_col;
    logic [1:0]       w_col_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [1:0]       r_row;
    logic [1:0]       w_row_next;
    logic             w_accept;
    logic [3:0]       w_code;

    logic             r_key_valid;
    logic [3:0]       r_key_code;
    logic             r_overrun;
    logic [31:0]      r_entry;

    sync_2ff #(
        .WIDTH     (4),
        .RESET_VAL (4'hF)
    ) u_row_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (row_n),
        .q     (w_row_s)
    );

    assign w_sample   = (r_dwell == DW'(SCAN_DIV - 1));
    assign w_all_high = &w_row_s;

    // Dwell counter: free-running 0..SCAN_DIV-1; every FSM move happens on
    // the wrap, so a column advance always starts with a fresh count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dwell <= '0;
        end else if (w_sample) begin
            r_dwell <= '0;
        end else begin
            r_dwell <= r_dwell + 1'b1;
        end
    end

    // FSM state register with column, agree/release counter and latched row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SCAN;
            r_col   <= 2'd0;
            r_cnt   <= '0;
            r_row   <= 2'd0;
        end else begin
            r_state <= w_state_next;
            r_col   <= w_col_next;
            r_cnt   <= w_cnt_next;
            r_row   <= w_row_next;
        end
    end

    // Next-state logic; decisions are only taken at sample points.
    always_comb begin
        w_state_next = r_state;
        w_col_next   = r_col;
        w_cnt_next   = r_cnt;
        w_row_next   = r_row;
        w_accept     = 1'b0;
        if (w_sample) begin
            case (r_state)
                SCAN: begin
                    if (w_all_high) begin
                        w_col_next = r_col + 2'd1;
                    end else begin
                        w_row_next = lowest_low_row(w_row_s);
                        if (DEBOUNCE_CNT == 1) begin
                            w_accept     = 1'b1;
                            w_state_next = HELD;
                            w_cnt_next   = '0;
                        end else begin
                            w_state_next = DEBOUNCE;
                            w_cnt_next   = CNT_W'(1);
                        end
                    end
                end
                DEBOUNCE: begin
                    if (!w_row_s[r_row]) begin
                        if (r_cnt == CNT_W'(DEBOUNCE_CNT - 1)) begin
                            w_accept     = 1'b1;
                            w_state_next = HELD;
                            w_cnt_next   = '0;
                        end else begin
                            w_cnt_next = r_cnt + 1'b1;
                        end
                    end else begin
                        // Bounce: drop the candidate silently and move on.
                        w_state_next = SCAN;
                        w_col_next   = r_col + 2'd1;
                        w_cnt_next   = '0;
                    end
                end
                HELD: begin
                    if (w_all_high) begin
                        if (r_cnt == CNT_W'(DEBOUNCE_CNT - 1)) begin
                            w_state_next = SCAN;
                            w_col_next   = 2'd0;
                            w_cnt_next   = '0;
                        end else begin
                            w_cnt_next = r_cnt + 1'b1;
                        end
                    end else begin
                        w_cnt_next = '0;
                    end
                end
                default: begin
                    w_state_next = SCAN;
                    w_col_next   = 2'd0;
                    w_cnt_next   = '0;
                end
            endcase
        end
    end

    // The accepted code uses the row being latched this cycle, so the
    // single-sample debounce case sees the fresh row.
    assign w_code = KEYMAP[{w_row_next, r_col}];

    // Key presentation, overrun flag and entry word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key_valid <= 1'b0;
            r_key_code  <= 4'h0;
            r_overrun   <= 1'b0;
            r_entry     <= 32'h0;
        end else begin
            if (w_accept) begin
                r_key_valid <= 1'b1;
                r_key_code  <= w_code;
            end else if (key_ack) begin
                r_key_valid <= 1'b0;
            end

            if (clr) begin
                r_overrun <= 1'b0;
            end else if (w_accept && r_key_valid && !key_ack) begin
                r_overrun <= 1'b1;
            end

            if (clr && w_accept) begin
                r_entry <= {28'h0, w_code};
            end else if (clr) begin
                r_entry <= 32'h0;
            end else if (w_accept) begin
                r_entry <= {r_entry[27:0], w_code};
            end
        end
    end

    assign col_n     = COL_N_TABLE[r_col];
    assign key_valid = r_key_valid;
    assign key_code  = r_key_code;
    assign key_held  = (r_state == HELD);
    assign overrun   = r_overrun;
    assign entry     = r_entry;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner with a behavioural 4x4 keypad model.
module tb_keypad_scanner;
  import keypad_pkg::*;

  localparam int SCAN_DIV     = 4;
  localparam int DEBOUNCE_CNT = 3;
  localparam int MAX_LAT      = (4 + DEBOUNCE_CNT) * SCAN_DIV + 3;

  typedef struct {
    logic [1:0] row;
    logic [1:0] col;
    logic [3:0] code;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_ack = 1'b0;
  logic        key_held;
  logic        overrun;
  logic        clr = 1'b0;
  logic [31:0] entry;
  state_t      dbg_state;

  logic [15:0] keys = '0;   // keys[row*4+col] = 1 when that key is down

  int n_tests = 0;
  int n_fail  = 0;

  vec_t tbl[16];

  // expected-value model state
  logic [31:0] m_entry;
  logic        m_valid;
  logic        m_ov;

  keypad_scanner #(
    .SCAN_DIV     (SCAN_DIV),
    .DEBOUNCE_CNT (DEBOUNCE_CNT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row_n     (row_n),
    .col_n     (col_n),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_ack   (key_ack),
    .key_held  (key_held),
    .overrun   (overrun),
    .clr       (clr),
    .entry     (entry),
    .dbg_state (dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // keypad matrix: a pressed key shorts its row to its column
  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic sig_of(input int which);
    case (which)
      0:       return key_held;
      1:       return key_valid;
      default: return (dbg_state == DEBOUNCE);
    endcase
  endfunction

  // wait on negedges until signal reaches level, bounded; the final level is checked
  task automatic wait_sig(input string name, input int which, input logic lvl,
                          input int bound, output int cyc);
    cyc = 0;
    while (sig_of(which) !== lvl && cyc < bound) begin
      @(negedge clk);
      cyc++;
    end
    check(name, sig_of(which), lvl);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic pulse_ack();
    key_ack = 1'b1;
    @(negedge clk);
    key_ack = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic press(input int idx);
    keys = '0;
    keys[idx] = 1'b1;
  endtask

  task automatic release_all(input string name);
    int cyc;
    keys = '0;
    wait_sig({name, " release"}, 0, 1'b0, 40, cyc);
    check({name, " col0 after release"}, col_n, 4'b1110);
  endtask

  initial begin
    int cyc;
    int idx;
    logic [3:0] exp_col;
    logic [15:0] row_codes[4];
    logic [31:0] saved;

    row_codes[0] = 16'h123A;
    row_codes[1] = 16'h456B;
    row_codes[2] = 16'h789C;
    row_codes[3] = 16'h0FED;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        tbl[r*4+c].row  = 2'(r);
        tbl[r*4+c].col  = 2'(c);
        tbl[r*4+c].code = row_codes[r][15-4*c -: 4];
      end

    // ---------- reset ----------
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("reset col_n", col_n, 4'b1110);
    check("reset key_valid", key_valid, 0);
    check("reset key_code", key_code, 0);
    check("reset key_held", key_held, 0);
    check("reset overrun", overrun, 0);
    check("reset entry", entry, 0);
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      exp_col = ~(4'(1) << ((i / 4) % 4));
      check($sformatf("scan col cycle %0d", i), col_n, exp_col);
      check($sformatf("scan idle valid %0d", i), key_valid, 0);
    end

    // ---------- single press r1/col2 ----------
    press(6);
    wait_sig("single press held", 0, 1'b1, 40, cyc);
    check("single press latency bound", (cyc <= MAX_LAT), 1);
    check("single press valid", key_valid, 1);
    check("single press code", key_code, 4'h6);
    check("single press entry", entry, 32'h6);
    repeat (40) @(negedge clk);
    check("held col stays driven", col_n, 4'b1011);
    check("held no repeat entry", entry, 32'h6);
    check("held no repeat overrun", overrun, 0);
    check("held still valid", key_valid, 1);
    pulse_ack();
    check("ack clears valid", key_valid, 0);
    check("code stable after ack", key_code, 4'h6);
    release_all("single");

    // ---------- table: every key ----------
    pulse_clr();
    check("clr entry", entry, 0);
    m_entry = 32'h0;
    for (int i = 0; i < 16; i++) begin
      press(int'(tbl[i].row) * 4 + int'(tbl[i].col));
      wait_sig($sformatf("tbl %0d held", i), 0, 1'b1, 40, cyc);
      m_entry = {m_entry[27:0], tbl[i].code};
      check($sformatf("tbl r%0dc%0d code", tbl[i].row, tbl[i].col), key_code, tbl[i].code);
      check($sformatf("tbl %0d entry", i), entry, m_entry);
      pulse_ack();
      release_all($sformatf("tbl %0d", i));
    end

    // ---------- bounce on r0/col0 ----------
    saved = entry;
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      if (i % 3 == 0) keys[0] = ~keys[0];
      @(negedge clk);
      if (key_held || key_valid) cyc++;
    end
    check("bounce no accept", cyc, 0);
    check("bounce entry unchanged", entry, saved);
    keys[0] = 1'b1;
    wait_sig("bounce settle held", 0, 1'b1, 40, cyc);
    check("bounce code", key_code, 4'h1);
    check("bounce entry", entry, {saved[27:0], 4'h1});
    pulse_ack();
    release_all("bounce");

    // ---------- overrun then clr ----------
    pulse_clr();
    press(0);
    wait_sig("ovr first held", 0, 1'b1, 40, cyc);
    release_all("ovr first");
    press(1);
    wait_sig("ovr second held", 0, 1'b1, 40, cyc);
    check("ovr code", key_code, 4'h2);
    check("ovr flag", overrun, 1);
    check("ovr entry", entry, 32'h12);
    pulse_clr();
    check("clr entry after ovr", entry, 0);
    check("clr overrun", overrun, 0);
    check("clr keeps valid", key_valid, 1);
    pulse_ack();
    release_all("ovr second");

    // ---------- ack on the accept cycle of D ----------
    pulse_clr();
    press(5);
    wait_sig("ackacc first held", 0, 1'b1, 40, cyc);
    release_all("ackacc first");
    press(15);
    wait_sig("ackacc debounce", 2, 1'b1, 40, cyc);
    repeat (7) @(negedge clk);
    check("ackacc before accept", key_held, 0);
    key_ack = 1'b1;
    @(negedge clk);
    key_ack = 1'b0;
    check("ackacc accept edge", key_held, 1);
    check("ackacc valid stays", key_valid, 1);
    check("ackacc code", key_code, 4'hD);
    check("ackacc overrun", overrun, 0);
    check("ackacc entry", entry, 32'h5D);
    pulse_ack();
    release_all("ackacc D");

    // ---------- reset mid-press ----------
    press(9);
    wait_sig("midrst debounce", 2, 1'b1, 40, cyc);
    rst_n = 1'b0;
    #1;
    check("midrst col_n", col_n, 4'b1110);
    check("midrst valid", key_valid, 0);
    check("midrst code", key_code, 0);
    check("midrst held", key_held, 0);
    check("midrst overrun", overrun, 0);
    check("midrst entry", entry, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_sig("midrst redetect held", 0, 1'b1, 40, cyc);
    check("midrst redetect code", key_code, 4'h8);
    check("midrst redetect entry", entry, 32'h8);
    pulse_ack();
    release_all("midrst");

    // ---------- randomized presses against model ----------
    pulse_clr();
    m_entry = 32'h0;
    m_valid = 1'b0;
    m_ov    = 1'b0;
    for (int it = 0; it < 24; it++) begin
      if ($urandom_range(0, 5) == 0) begin
        pulse_clr();
        m_entry = 32'h0;
        m_ov    = 1'b0;
      end
      if (!m_valid && $urandom_range(0, 3) == 0) pulse_ack();
      idx = int'($urandom_range(0, 15));
      press(idx);
      wait_sig($sformatf("rnd %0d held", it), 0, 1'b1, 40, cyc);
      if (m_valid) m_ov = 1'b1;
      m_valid = 1'b1;
      m_entry = {m_entry[27:0], tbl[idx].code};
      check($sformatf("rnd %0d code", it), key_code, tbl[idx].code);
      check($sformatf("rnd %0d entry", it), entry, m_entry);
      check($sformatf("rnd %0d overrun", it), overrun, m_ov);
      check($sformatf("rnd %0d valid", it), key_valid, 1);
      repeat ($urandom_range(0, 20)) @(negedge clk);
      check($sformatf("rnd %0d no repeat", it), entry, m_entry);
      if ($urandom_range(0, 1) == 1) begin
        pulse_ack();
        m_valid = 1'b0;
        check($sformatf("rnd %0d ack", it), key_valid, 0);
      end
      release_all($sformatf("rnd %0d", it));
      repeat ($urandom_range(0, 8)) @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
